adder_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined `adder` instance among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the adder. A tag pipeline tracks the requester ID through the adder latency, and results return on a single response bus in issue order. A credit-protected result FIFO absorbs response backpressure, so the adder pipeline itself is never stalled.

---
 rtl/adder_arbiter.sv | 177 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin scheduler sharing one pipelined adder among NREQ requesters.
// Tags follow each issue through the adder; a credit-guarded FWFT FIFO returns results in issue order.
module adder_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DATAW      = 32,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDW        = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int unsigned CNTW       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*DATAW-1:0] req_dataa_i,
    input  logic [NREQ*DATAW-1:0] req_datab_i,
    output logic                  add_valid_o,
    output logic [DATAW-1:0]      add_dataa_o,
    output logic [DATAW-1:0]      add_datab_o,
    input  logic [DATAW-1:0]      add_sum_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATAW-1:0]      resp_sum_o,
    output logic [IDW-1:0]        resp_id_o,
    output logic [CNTW-1:0]       outstanding_o
);

    localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [IDW-1:0]   r_ptr;
    logic [CNTW-1:0]  r_outst;
    logic [DATAW-1:0] r_last_a;
    logic [DATAW-1:0] r_last_b;

    logic [IDW-1:0]   w_grant;
    logic             w_found;
    int unsigned      w_idx;
    logic             w_issue;
    logic             w_pop;
    logic             w_push;
    logic [IDW-1:0]   w_push_id;
    logic [DATAW-1:0] w_sel_a;
    logic [DATAW-1:0] w_sel_b;

    // Round-robin search: first valid index at or after r_ptr, wrapping at NREQ.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = (32'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid_i[w_idx]) begin
                w_grant = IDW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_issue = (|req_valid_i) && (32'(r_outst) < FIFO_DEPTH);
    assign w_pop   = resp_valid_o && resp_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (w_issue) begin
            req_ready_o[w_grant] = 1'b1;
        end
    end

    assign w_sel_a = req_dataa_i[32'(w_grant) * DATAW +: DATAW];
    assign w_sel_b = req_datab_i[32'(w_grant) * DATAW +: DATAW];

    // Operands hold the last issued pair between issues.
    assign add_valid_o = w_issue;
    assign add_dataa_o = w_issue ? w_sel_a : r_last_a;
    assign add_datab_o = w_issue ? w_sel_b : r_last_b;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr    <= '0;
            r_outst  <= '0;
            r_last_a <= '0;
            r_last_b <= '0;
        end else begin
            if (w_issue) begin
                r_ptr    <= (32'(w_grant) == NREQ - 1) ? '0 : w_grant + 1'b1;
                r_last_a <= w_sel_a;
                r_last_b <= w_sel_b;
            end
            if (w_issue && !w_pop) begin
                r_outst <= r_outst + 1'b1;
            end else if (!w_issue && w_pop) begin
                r_outst <= r_outst - 1'b1;
            end
        end
    end

    assign outstanding_o = r_outst;

    // Tag pipeline mirrors the adder latency and is never stalled.
    if (LATENCY == 0) begin : g_tag_comb
        assign w_push    = w_issue;
        assign w_push_id = w_grant;
    end else begin : g_tag_pipe
        logic [LATENCY-1:0] r_tag_vld;
        logic [IDW-1:0]     r_tag_id [LATENCY];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_tag_vld <= '0;
                for (int unsigned i = 0; i < LATENCY; i++) begin
                    r_tag_id[i] <= '0;
                end
            end else begin
                r_tag_vld[0] <= w_issue;
                r_tag_id[0]  <= w_grant;
                for (int unsigned i = 1; i < LATENCY; i++) begin
                    r_tag_vld[i] <= r_tag_vld[i-1];
                    r_tag_id[i]  <= r_tag_id[i-1];
                end
            end
        end

        assign w_push    = r_tag_vld[LATENCY-1];
        assign w_push_id = r_tag_id[LATENCY-1];
    end

    // Result FIFO; credits guarantee it never overflows.
    logic [DATAW-1:0] r_mem_sum [FIFO_DEPTH];
    logic [IDW-1:0]   r_mem_id  [FIFO_DEPTH];
    logic [PTRW-1:0]  r_wr;
    logic [PTRW-1:0]  r_rd;
    logic [CNTW-1:0]  r_cnt;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_sum[r_wr] <= add_sum_i;
            r_mem_id[r_wr]  <= w_push_id;
        end
    end

    // Head is masked while empty so the storage itself needs no reset.
    assign resp_valid_o = (r_cnt != '0);
    assign resp_sum_o   = resp_valid_o ? r_mem_sum[r_rd] : '0;
    assign resp_id_o    = resp_valid_o ? r_mem_id[r_rd] : '0;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && !w_pop && (32'(r_cnt) == FIFO_DEPTH)));
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table of single ops plus hand-written
// saturation, backpressure, pointer-skip and mid-operation reset sequences.
module tb_adder_arbiter;

    localparam int unsigned NREQ       = 4;
    localparam int unsigned DATAW      = 32;
    localparam int unsigned LATENCY    = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DATAW-1:0] req_dataa;
    logic [NREQ*DATAW-1:0] req_datab;
    logic                  add_valid;
    logic [DATAW-1:0]      add_dataa;
    logic [DATAW-1:0]      add_datab;
    logic [DATAW-1:0]      add_sum;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATAW-1:0]      resp_sum;
    logic [1:0]            resp_id;
    logic [2:0]            outstanding;

    always #5 clk = ~clk;

    adder_arbiter #(
        .NREQ       (NREQ),
        .DATAW      (DATAW),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_dataa_i   (req_dataa),
        .req_datab_i   (req_datab),
        .add_valid_o   (add_valid),
        .add_dataa_o   (add_dataa),
        .add_datab_o   (add_datab),
        .add_sum_i     (add_sum),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_sum_o    (resp_sum),
        .resp_id_o     (resp_id),
        .outstanding_o (outstanding)
    );

    // Two-stage pipelined adder model
    logic [DATAW-1:0] s1, s2;
    always @(posedge clk) begin
        s1 <= add_dataa + add_datab;
        s2 <= s1;
    end
    assign add_sum = s2;

    typedef struct {
        logic [1:0]       id;
        logic [DATAW-1:0] sum;
    } exp_t;

    typedef struct {
        int unsigned      id;
        logic [DATAW-1:0] a;
        logic [DATAW-1:0] b;
        logic [DATAW-1:0] sum;
    } vec_t;

    exp_t             exp_q[$];
    vec_t             vecs [6];
    logic [DATAW-1:0] sa [NREQ];
    logic [DATAW-1:0] sb [NREQ];
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [DATAW-1:0] a, input logic [DATAW-1:0] b);
        sa[r] = a;
        sb[r] = b;
        req_dataa[r*DATAW +: DATAW] = a;
        req_datab[r*DATAW +: DATAW] = b;
    endtask

    task automatic push_exp(input int g);
        exp_q.push_back('{id: 2'(g), sum: sa[g] + sb[g]});
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        next();
        @(negedge clk);
        check("drain_outstanding", 64'(outstanding), 64'd0);
        next();
    endtask

    // Response scoreboard: every pop must match the next expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got id %0d sum %0h, required no response",
                             resp_id, resp_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id", 64'(resp_id), 64'(e.id));
                    check("resp_sum", 64'(resp_sum), 64'(e.sum));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] want_r;
        int              n;
        int              k;

        vecs[0] = '{0, 32'd5,        32'd7,        32'd12};
        vecs[1] = '{1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vecs[2] = '{2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[3] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[4] = '{2, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[5] = '{3, 32'h12345678, 32'h11111111, 32'h23456789};

        rst        = 1'b1;
        req_valid  = '0;
        req_dataa  = '0;
        req_datab  = '0;
        resp_ready = 1'b1;
        for (int r = 0; r < int'(NREQ); r++) set_req(r, '0, '0);
        next();
        next();
        rst = 1'b0;

        @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_add_valid", 64'(add_valid), 64'd0);
        check("rst_resp_sum", 64'(resp_sum), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_add_dataa", 64'(add_dataa), 64'd0);
        check("rst_add_datab", 64'(add_datab), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        next();

        // Single ops from the vector table
        for (int i = 0; i < 6; i++) begin
            set_req(int'(vecs[i].id), vecs[i].a, vecs[i].b);
            req_valid = '0;
            req_valid[vecs[i].id] = 1'b1;
            @(negedge clk);
            want_r = '0;
            want_r[vecs[i].id] = 1'b1;
            check("vec_grant", 64'(req_ready), 64'(want_r));
            check("vec_add_valid", 64'(add_valid), 64'd1);
            check("vec_add_dataa", 64'(add_dataa), 64'(vecs[i].a));
            check("vec_add_datab", 64'(add_datab), 64'(vecs[i].b));
            exp_q.push_back('{id: 2'(vecs[i].id), sum: vecs[i].sum});
            next();
            req_valid = '0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!resp_valid && n < 10);
            check("vec_latency", 64'(n), 64'(LATENCY + 1));
            next();
            @(negedge clk);
            check("vec_outstanding", 64'(outstanding), 64'd0);
            check("vec_resp_idle", 64'(resp_valid), 64'd0);
            next();
        end

        // Saturation: all valid, grants rotate 0..3 at one per cycle
        k = 1;
        for (int r = 0; r < int'(NREQ); r++) set_req(r, 32'(r * 10 + 1), 32'(r * 100));
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            want_r = 4'b0001 << (c % 4);
            check("sat_grant", 64'(req_ready), 64'(want_r));
            push_exp(c % 4);
            next();
            set_req(c % 4, 32'(k), 32'(k * 3));
            k++;
        end
        req_valid = '0;
        drain();

        // Backpressure: four accepts fill the credits, issue resumes after first pop
        resp_ready = 1'b0;
        req_valid  = '1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                want_r = 4'b0001 << c;
                check("bp_grant", 64'(req_ready), 64'(want_r));
                push_exp(c);
            end else begin
                check("bp_blocked", 64'(req_ready), 64'd0);
                check("bp_outstanding", 64'(outstanding), 64'd4);
                check("bp_resp_valid", 64'(resp_valid), 64'd1);
                check("bp_head_id", 64'(resp_id), 64'(exp_q[0].id));
                check("bp_head_sum", 64'(resp_sum), 64'(exp_q[0].sum));
            end
            next();
            if (c < 4) begin
                set_req(c, 32'(k), 32'(k * 3));
                k++;
            end
            if (c == 5) resp_ready = 1'b1;
        end
        @(negedge clk);
        check("bp_pop_cycle_blocked", 64'(req_ready), 64'd0);
        next();
        @(negedge clk);
        check("bp_resume_grant", 64'(req_ready), 64'b0001);
        push_exp(0);
        next();
        req_valid = '0;
        drain();

        // Pointer skip: req0 granted, then req0+req2 valid gives req2 then req0
        set_req(0, 32'd40, 32'd2);
        req_valid = 4'b0001;
        @(negedge clk);
        check("skip_first", 64'(req_ready), 64'b0001);
        push_exp(0);
        next();
        set_req(0, 32'd100, 32'd23);
        set_req(2, 32'd7, 32'd8);
        req_valid = 4'b0101;
        @(negedge clk);
        check("skip_req2", 64'(req_ready), 64'b0100);
        push_exp(2);
        next();
        set_req(2, 32'd9, 32'd9);
        @(negedge clk);
        check("skip_req0", 64'(req_ready), 64'b0001);
        push_exp(0);
        next();
        req_valid = '0;
        drain();

        // Reset with two ops in flight: both are discarded
        set_req(0, 32'd1, 32'd1);
        set_req(1, 32'd2, 32'd2);
        req_valid = 4'b0011;
        @(negedge clk);
        check("rmo_grant1", 64'(req_ready), 64'b0010);
        next();
        @(negedge clk);
        check("rmo_grant0", 64'(req_ready), 64'b0001);
        next();
        req_valid = '0;
        rst       = 1'b1;
        next();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rmo_resp_valid", 64'(resp_valid), 64'd0);
            check("rmo_outstanding", 64'(outstanding), 64'd0);
        end
        next();
        for (int r = 0; r < int'(NREQ); r++) set_req(r, 32'(r + 50), 32'(r + 60));
        req_valid = '1;
        @(negedge clk);
        check("rmo_first_grant", 64'(req_ready), 64'b0001);
        push_exp(0);
        next();
        req_valid = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
